disp_vramresp: RTL and testbench
================================

DISP_VRAMRESP -- requirements
Module: disp_vramresp

Interface
REQ-001 Parameter BASE_ADDR, default 32'h2000_0000, byte address of VRAM word 0.
REQ-002 Parameter MEM_WORDS, default 65536, number of 32-bit VRAM words; SHALL be a power of two no greater than 65536.
REQ-003 ACLK  input  1  single clock; all logic SHALL be synchronous to its rising edge.
REQ-004 ARST  input  1  reset, synchronous, active-high.
REQ-005 ARADDR  input  32  burst start byte address.
REQ-006 ARLEN  input  8  beats minus one; only bits [3:0] are used, giving 1..16 beats.
REQ-007 ARVALID  input  1  read address valid.
REQ-008 ARREADY  output  1  read address accepted.
REQ-009 RDATA  output  32  read data beat.
REQ-010 RRESP  output  2  2'b00 OKAY, 2'b10 SLVERR.
REQ-011 RLAST  output  1  final beat of the burst.
REQ-012 RVALID  output  1  read data valid.
REQ-013 RREADY  input  1  master accepts the beat.
REQ-014 MEM_ADDR  output  16  VRAM word address.
REQ-015 MEM_RE  output  1  VRAM read strobe.
REQ-016 MEM_RDATA  input  32  VRAM data, valid exactly one cycle after MEM_RE.

Function
REQ-017 The block SHALL implement an AXI read responder with two states, S_IDLE and S_BURST, one-hot encoded.
REQ-018 ARREADY SHALL be registered and high only in S_IDLE; the block accepts one outstanding burst at a time.
REQ-019 On ARVALID&ARREADY the block SHALL latch ARADDR, the low 4 bits of ARLEN, and the beat counters, then enter S_BURST on the next edge.
REQ-020 ARADDR[1:0] SHALL be ignored; beat k uses byte address {ARADDR[31:2],2'b00} + 4*k, burst type INCR only, with no 4 KB boundary check.
REQ-021 A beat SHALL be out of range when its byte address < BASE_ADDR or its word index ((addr - BASE_ADDR) >> 2) >= MEM_WORDS; the subtraction is 32-bit.
REQ-022 Storage SHALL be a 2-entry output FIFO holding {RDATA, RRESP, RLAST}; RVALID = FIFO not empty; RDATA/RRESP/RLAST = FIFO head.
REQ-023 In S_BURST, a beat SHALL be issued in a cycle when beats remain to issue and (fifo_count + inflight - pop) < 2, where pop = RVALID&RREADY and inflight is the beat issued in the previous cycle (0 or 1).
REQ-024 Issuing an in-range beat SHALL assert MEM_RE for one cycle with MEM_ADDR = the word index[15:0]; the FIFO is written on the next edge from MEM_RDATA with RRESP 2'b00.
REQ-025 Issuing an out-of-range beat SHALL NOT assert MEM_RE; the FIFO SHALL receive RDATA 0 and RRESP 2'b10 with the same one-cycle slot timing, and the burst continues.
REQ-026 RLAST SHALL be set only on the entry for beat ARLEN[3:0].
REQ-027 Simultaneous FIFO push and pop SHALL leave the count unchanged; a push to a full FIFO cannot occur under REQ-023.
REQ-028 Latency: AR handshake at edge T gives MEM_RE in cycle T+1, and first RVALID after edge T+2.
REQ-029 Throughput: with RREADY held high, one beat per cycle, so a 16-beat burst completes in 16 consecutive cycles.
REQ-030 RDATA/RRESP/RLAST SHALL stay stable while RVALID is high and RREADY is low.
REQ-031 On the RLAST handshake the block SHALL return to S_IDLE, and ARREADY SHALL be high in the following cycle.
REQ-032 MEM_ADDR SHALL hold its last value while MEM_RE is low.

Reset
REQ-033 While ARST is high: state S_IDLE; ARREADY, RVALID, RLAST, MEM_RE = 0; RDATA, RRESP, MEM_ADDR = 0; FIFO, inflight, and counters cleared.
REQ-034 ARREADY SHALL first rise in the cycle after ARST deasserts.
REQ-035 Reset asserted mid-burst SHALL abort the burst without issuing further beats; any in-flight MEM_RDATA SHALL be discarded.

Verification
REQ-036 Reset, then ARADDR=BASE_ADDR, ARLEN=7, RREADY=1, memory word i = i -> RDATA 0..7 on 8 consecutive cycles, RRESP 0, RLAST only on data 7, first RVALID 2 cycles after the AR handshake.
REQ-037 ARLEN=15, RREADY toggling 1,0,0,1,... (random) -> 16 beats in order, no loss or duplication, outputs stable while stalled, MEM_RE never high with a full FIFO.
REQ-038 ARADDR=BASE_ADDR+4*(MEM_WORDS-2), ARLEN=3 -> beats 0-1 OKAY with memory data, beats 2-3 SLVERR with RDATA 0, MEM_RE pulsed exactly twice.
REQ-039 ARADDR=BASE_ADDR-4, ARLEN=0 -> single beat, RDATA 0, RRESP 2'b10, RLAST 1, no MEM_RE.
REQ-040 ARST pulsed for one cycle after beat 3 of a 16-beat burst -> all outputs 0 during reset, ARREADY=1 the next cycle, a new burst returns correct data from its own address.
REQ-041 Back-to-back: ARVALID held high with two queued requests -> second ARREADY one cycle after the first burst's RLAST handshake, and bursts never overlap.

Source files
------------

// File: rtl/disp_vramresp.sv
// AXI read responder that serves INCR bursts from a 32-bit VRAM port.
// Ports: ACLK/ARST, AR channel (ARADDR/ARLEN/ARVALID/ARREADY),
//        R channel (RDATA/RRESP/RLAST/RVALID/RREADY),
//        VRAM port (MEM_ADDR/MEM_RE out, MEM_RDATA in, one-cycle latency).
module disp_vramresp #(
    parameter logic [31:0] BASE_ADDR = 32'h2000_0000,
    parameter int          MEM_WORDS = 65536
) (
    input  logic        ACLK,
    input  logic        ARST,
    input  logic [31:0] ARADDR,
    input  logic [7:0]  ARLEN,
    input  logic        ARVALID,
    output logic        ARREADY,
    output logic [31:0] RDATA,
    output logic [1:0]  RRESP,
    output logic        RLAST,
    output logic        RVALID,
    input  logic        RREADY,
    output logic [15:0] MEM_ADDR,
    output logic        MEM_RE,
    input  logic [31:0] MEM_RDATA
);

    localparam logic [1:0]  S_IDLE  = 2'b01;
    localparam logic [1:0]  S_BURST = 2'b10;
    localparam logic [29:0] MW      = 30'(MEM_WORDS);

    logic [1:0]       state_q, state_d;
    logic             arready_q, arready_d;
    logic [31:0]      addr_q;
    logic [3:0]       len_q;
    logic [4:0]       icnt_q;
    logic             infl_q, infl_oor_q, infl_last_q;
    logic [15:0]      mem_addr_q;
    logic [1:0][31:0] fdata_q;
    logic [1:0][1:0]  fresp_q;
    logic [1:0]       flast_q;
    logic             rptr_q, wptr_q;
    logic [1:0]       cnt_q;

    logic        ar_hs, pop, push, more, issue, oor, head_last;
    logic [2:0]  occ;
    logic [31:0] beat_off;

    logic unused_ok;
    assign unused_ok = ^{ARLEN[7:4], ARADDR[1:0], beat_off[1:0]};

    assign ar_hs     = ARVALID & arready_q;
    assign pop       = (cnt_q != 2'd0) & RREADY;
    assign push      = infl_q;
    assign head_last = flast_q[rptr_q];

    // State register
    always_ff @(posedge ACLK) begin
        if (ARST) state_q <= S_IDLE;
        else      state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (1'b1)
            state_q[0]: if (ar_hs) state_d = S_BURST;
            state_q[1]: if (pop && head_last) state_d = S_IDLE;
            default:    state_d = S_IDLE;
        endcase
    end

    // Output / issue logic
    always_comb begin
        arready_d = state_d[0];
        beat_off  = addr_q - BASE_ADDR;
        oor       = (addr_q < BASE_ADDR) || (beat_off[31:2] >= MW);
        more      = icnt_q <= {1'b0, len_q};
        // Slots already claimed: FIFO entries plus the beat whose
        // memory data arrives next edge, minus the one leaving now.
        occ       = {1'b0, cnt_q} + {2'b00, infl_q} - {2'b00, pop};
        issue     = state_q[1] && more && (occ < 3'd2) && !ARST;
        MEM_RE    = issue && !oor;
        MEM_ADDR  = ARST ? 16'h0 : (MEM_RE ? beat_off[17:2] : mem_addr_q);
        RVALID    = cnt_q != 2'd0;
        RDATA     = RVALID ? fdata_q[rptr_q] : 32'h0;
        RRESP     = RVALID ? fresp_q[rptr_q] : 2'b00;
        RLAST     = RVALID ? head_last : 1'b0;
        ARREADY   = arready_q;
    end

    always_ff @(posedge ACLK) begin
        if (ARST) begin
            arready_q   <= 1'b0;
            addr_q      <= '0;
            len_q       <= '0;
            icnt_q      <= '0;
            infl_q      <= 1'b0;
            infl_oor_q  <= 1'b0;
            infl_last_q <= 1'b0;
            mem_addr_q  <= '0;
            fdata_q     <= '0;
            fresp_q     <= '0;
            flast_q     <= '0;
            rptr_q      <= 1'b0;
            wptr_q      <= 1'b0;
            cnt_q       <= '0;
        end else begin
            arready_q <= arready_d;
            if (ar_hs) begin
                addr_q <= {ARADDR[31:2], 2'b00};
                len_q  <= ARLEN[3:0];
                icnt_q <= '0;
            end else if (issue) begin
                addr_q <= addr_q + 32'd4;
                icnt_q <= icnt_q + 5'd1;
            end
            infl_q      <= issue;
            infl_oor_q  <= oor;
            infl_last_q <= icnt_q[3:0] == len_q;
            if (MEM_RE) mem_addr_q <= beat_off[17:2];
            if (push) begin
                fdata_q[wptr_q] <= infl_oor_q ? 32'h0 : MEM_RDATA;
                fresp_q[wptr_q] <= infl_oor_q ? 2'b10 : 2'b00;
                flast_q[wptr_q] <= infl_last_q;
                wptr_q          <= ~wptr_q;
            end
            if (pop) rptr_q <= ~rptr_q;
            cnt_q <= cnt_q + {1'b0, push} - {1'b0, pop};
        end
    end

endmodule

// File: tb/tb_disp_vramresp.sv
// Directed self-checking bench for disp_vramresp.
// VRAM model returns {16'h0, word address}; idle cycles return DEADBEEF.
module tb_disp_vramresp;

    localparam logic [31:0] BASE = 32'h2000_0000;
    localparam int          MW   = 65536;

    logic        clk = 1'b0;
    logic        ARST = 1'b1;
    logic [31:0] ARADDR = '0;
    logic [7:0]  ARLEN = '0;
    logic        ARVALID = 1'b0;
    logic        ARREADY;
    logic [31:0] RDATA;
    logic [1:0]  RRESP;
    logic        RLAST;
    logic        RVALID;
    logic        RREADY = 1'b0;
    logic [15:0] MEM_ADDR;
    logic        MEM_RE;
    logic [31:0] MEM_RDATA = 32'hDEAD_BEEF;

    int checks = 0;
    int failures = 0;

    int re_total = 0;
    int occ = 0;
    int viol = 0;
    logic        re_n = 1'b0;
    logic [15:0] ad_n = '0;

    disp_vramresp #(.BASE_ADDR(BASE), .MEM_WORDS(MW)) dut (
        .ACLK(clk), .ARST(ARST),
        .ARADDR(ARADDR), .ARLEN(ARLEN), .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID),
        .RREADY(RREADY),
        .MEM_ADDR(MEM_ADDR), .MEM_RE(MEM_RE), .MEM_RDATA(MEM_RDATA)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        re_n <= MEM_RE;
        ad_n <= MEM_ADDR;
        if (MEM_RE) re_total <= re_total + 1;
        if (ARST) occ <= 0;
        else begin
            occ <= occ + int'(MEM_RE) - int'(RVALID && RREADY);
            if (MEM_RE && (occ - int'(RVALID && RREADY)) >= 2) viol <= viol + 1;
        end
    end

    always @(posedge clk)
        MEM_RDATA <= re_n ? {16'h0, ad_n} : 32'hDEAD_BEEF;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_ar(input logic [31:0] a, input logic [7:0] l);
        int n;
        n = 0;
        ARADDR = a;
        ARLEN = l;
        ARVALID = 1'b1;
        while (ARREADY !== 1'b1 && n < 50) begin
            step();
            n++;
        end
        checks++;
        if (n >= 50) begin
            failures++;
            $display("FAIL ar_timeout got=%0d exp<50", n);
        end
        step();
        ARVALID = 1'b0;
    endtask

    task automatic test_reset();
        logic [53:0] v;
        ARST = 1'b1;
        repeat (3) step();
        v = {ARREADY, RVALID, RLAST, MEM_RE, RRESP, RDATA, MEM_ADDR};
        checks++;
        if (v !== 54'h0) begin
            failures++;
            $display("FAIL reset_outputs got=%h exp=0", v);
        end
        ARST = 1'b0;
        checks++;
        if (ARREADY !== 1'b0) begin
            failures++;
            $display("FAIL reset_arready_early got=%b exp=0", ARREADY);
        end
        step();
        checks++;
        if (ARREADY !== 1'b1) begin
            failures++;
            $display("FAIL reset_arready_rise got=%b exp=1", ARREADY);
        end
    endtask

    task automatic test_basic();
        RREADY = 1'b1;
        do_ar(BASE, 8'd7);
        checks++;
        if (MEM_RE !== 1'b1 || MEM_ADDR !== 16'h0) begin
            failures++;
            $display("FAIL basic_first_re got=%b/%h exp=1/0000", MEM_RE, MEM_ADDR);
        end
        step();
        checks++;
        if (RVALID !== 1'b0) begin
            failures++;
            $display("FAIL basic_early_rvalid got=%b exp=0", RVALID);
        end
        for (int i = 0; i < 8; i++) begin
            step();
            checks++;
            if (RVALID !== 1'b1 || RDATA !== 32'(i) || RRESP !== 2'b00
                || RLAST !== (i == 7)) begin
                failures++;
                $display("FAIL basic_beat%0d got=%b/%h/%b/%b exp=1/%h/00/%b",
                         i, RVALID, RDATA, RRESP, RLAST, 32'(i), i == 7);
            end
        end
        step();
        checks++;
        if (ARREADY !== 1'b1 || RVALID !== 1'b0) begin
            failures++;
            $display("FAIL basic_return_idle got=%b/%b exp=1/0", ARREADY, RVALID);
        end
    endtask

    task automatic test_stall();
        int v0, got;
        logic rr, pstall;
        logic [34:0] pv;
        v0 = viol;
        got = 0;
        pstall = 1'b0;
        pv = '0;
        RREADY = 1'b0;
        do_ar(BASE + 32'd400, 8'd15);
        for (int c = 0; c < 400 && got < 16; c++) begin
            step();
            if (pstall) begin
                checks++;
                if (RVALID !== 1'b1 || {RDATA, RRESP, RLAST} !== pv) begin
                    failures++;
                    $display("FAIL stall_stable got=%b/%h exp=1/%h",
                             RVALID, {RDATA, RRESP, RLAST}, pv);
                end
            end
            rr = 1'($urandom_range(1, 0));
            RREADY = rr;
            if (RVALID && rr) begin
                checks++;
                if (RDATA !== 32'(100 + got) || RRESP !== 2'b00
                    || RLAST !== (got == 15)) begin
                    failures++;
                    $display("FAIL stall_beat%0d got=%h/%b/%b exp=%h/00/%b",
                             got, RDATA, RRESP, RLAST, 32'(100 + got), got == 15);
                end
                got++;
            end
            pstall = RVALID && !rr;
            pv = {RDATA, RRESP, RLAST};
        end
        checks++;
        if (got !== 16) begin
            failures++;
            $display("FAIL stall_count got=%0d exp=16", got);
        end
        RREADY = 1'b1;
        step();
        checks++;
        if (ARREADY !== 1'b1 || RVALID !== 1'b0) begin
            failures++;
            $display("FAIL stall_idle got=%b/%b exp=1/0", ARREADY, RVALID);
        end
        checks++;
        if (viol !== v0) begin
            failures++;
            $display("FAIL stall_re_full got=%0d exp=%0d", viol, v0);
        end
    endtask

    task automatic test_boundary();
        logic [31:0] ed [4];
        logic [1:0]  er [4];
        int r0, got;
        ed = '{32'h0000_FFFE, 32'h0000_FFFF, 32'h0, 32'h0};
        er = '{2'b00, 2'b00, 2'b10, 2'b10};
        r0 = re_total;
        got = 0;
        RREADY = 1'b1;
        do_ar(BASE + 32'(4 * (MW - 2)), 8'd3);
        for (int c = 0; c < 30 && got < 4; c++) begin
            step();
            if (RVALID) begin
                checks++;
                if (RDATA !== ed[got] || RRESP !== er[got] || RLAST !== (got == 3)) begin
                    failures++;
                    $display("FAIL bound_beat%0d got=%h/%b/%b exp=%h/%b/%b",
                             got, RDATA, RRESP, RLAST, ed[got], er[got], got == 3);
                end
                got++;
            end
        end
        step();
        checks++;
        if (got !== 4 || ARREADY !== 1'b1) begin
            failures++;
            $display("FAIL bound_done got=%0d/%b exp=4/1", got, ARREADY);
        end
        checks++;
        if (re_total - r0 !== 2) begin
            failures++;
            $display("FAIL bound_re_count got=%0d exp=2", re_total - r0);
        end
    endtask

    task automatic test_below();
        int r0, got;
        r0 = re_total;
        got = 0;
        RREADY = 1'b1;
        do_ar(BASE - 32'd4, 8'd0);
        for (int c = 0; c < 20 && got < 1; c++) begin
            step();
            if (RVALID) begin
                checks++;
                if (RDATA !== 32'h0 || RRESP !== 2'b10 || RLAST !== 1'b1) begin
                    failures++;
                    $display("FAIL below_beat got=%h/%b/%b exp=0/10/1",
                             RDATA, RRESP, RLAST);
                end
                got++;
            end
        end
        step();
        checks++;
        if (got !== 1 || ARREADY !== 1'b1 || RVALID !== 1'b0) begin
            failures++;
            $display("FAIL below_done got=%0d/%b/%b exp=1/1/0", got, ARREADY, RVALID);
        end
        checks++;
        if (re_total !== r0) begin
            failures++;
            $display("FAIL below_re_count got=%0d exp=0", re_total - r0);
        end
    endtask

    task automatic test_reset_mid();
        logic [53:0] v;
        int got;
        logic hit;
        got = 0;
        hit = 1'b0;
        RREADY = 1'b1;
        do_ar(BASE + 32'd128, 8'd15);
        for (int c = 0; c < 30 && !hit; c++) begin
            step();
            if (RVALID) begin
                checks++;
                if (RDATA !== 32'(32 + got)) begin
                    failures++;
                    $display("FAIL mid_beat%0d got=%h exp=%h", got, RDATA, 32'(32 + got));
                end
                if (got == 3) begin
                    ARST = 1'b1;
                    hit = 1'b1;
                end
                got++;
            end
        end
        step();
        v = {ARREADY, RVALID, RLAST, MEM_RE, RRESP, RDATA, MEM_ADDR};
        checks++;
        if (!hit || v !== 54'h0) begin
            failures++;
            $display("FAIL mid_reset_outputs got=%h/%b exp=0/1", v, hit);
        end
        ARST = 1'b0;
        step();
        checks++;
        if (ARREADY !== 1'b1 || RVALID !== 1'b0) begin
            failures++;
            $display("FAIL mid_after_reset got=%b/%b exp=1/0", ARREADY, RVALID);
        end
        step();
        checks++;
        if (RVALID !== 1'b0 || MEM_RE !== 1'b0) begin
            failures++;
            $display("FAIL mid_no_stale got=%b/%b exp=0/0", RVALID, MEM_RE);
        end
        got = 0;
        do_ar(BASE + 32'd2000, 8'd3);
        for (int c = 0; c < 30 && got < 4; c++) begin
            step();
            if (RVALID) begin
                checks++;
                if (RDATA !== 32'(500 + got) || RRESP !== 2'b00 || RLAST !== (got == 3)) begin
                    failures++;
                    $display("FAIL mid_new_beat%0d got=%h/%b exp=%h/%b",
                             got, RDATA, RLAST, 32'(500 + got), got == 3);
                end
                got++;
            end
        end
        step();
        checks++;
        if (got !== 4 || ARREADY !== 1'b1) begin
            failures++;
            $display("FAIL mid_new_done got=%0d/%b exp=4/1", got, ARREADY);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] ex [5];
        int beats, c_last, ovl;
        logic seen1, pend, done;
        ex = '{32'd10, 32'd11, 32'd20, 32'd21, 32'd22};
        beats = 0;
        c_last = -10;
        ovl = 0;
        seen1 = 1'b0;
        pend = 1'b0;
        done = 1'b0;
        RREADY = 1'b1;
        checks++;
        if (ARREADY !== 1'b1) begin
            failures++;
            $display("FAIL b2b_start got=%b exp=1", ARREADY);
        end
        ARADDR = BASE + 32'd40;
        ARLEN = 8'd1;
        ARVALID = 1'b1;
        step();
        ARADDR = BASE + 32'd80;
        ARLEN = 8'd2;
        for (int c = 0; c < 60 && !(done && beats == 5); c++) begin
            step();
            if (pend) begin
                ARVALID = 1'b0;
                pend = 1'b0;
                done = 1'b1;
            end
            if (RVALID && ARREADY) ovl++;
            if (ARREADY && !done) begin
                checks++;
                if (!seen1 || c != c_last + 1) begin
                    failures++;
                    $display("FAIL b2b_arready_cycle got=%0d exp=%0d", c, c_last + 1);
                end
                pend = 1'b1;
            end
            if (RVALID && beats < 5) begin
                checks++;
                if (RDATA !== ex[beats] || RLAST !== (beats == 1 || beats == 4)) begin
                    failures++;
                    $display("FAIL b2b_beat%0d got=%h/%b exp=%h/%b", beats, RDATA,
                             RLAST, ex[beats], beats == 1 || beats == 4);
                end
                if (RLAST && beats == 1) begin
                    seen1 = 1'b1;
                    c_last = c;
                end
                beats++;
            end
        end
        ARVALID = 1'b0;
        checks++;
        if (beats !== 5 || !done || ovl !== 0) begin
            failures++;
            $display("FAIL b2b_done got=%0d/%b/%0d exp=5/1/0", beats, done, ovl);
        end
        step();
        checks++;
        if (ARREADY !== 1'b1 || RVALID !== 1'b0) begin
            failures++;
            $display("FAIL b2b_idle got=%b/%b exp=1/0", ARREADY, RVALID);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_boundary();
        test_below();
        test_reset_mid();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
